// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// Build option: FORWARDING_EN (see hazard_stall_ctrl.sv).
package hazard_pkg;

    // Controller sequencing state.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    // r0 is hard-wired to zero, so it can never carry a true dependency.
    localparam int unsigned REG_ZERO = 0;

    // Operands arrive zero-extended to 32 bits so one helper serves any REG_AW.
    function automatic logic src_match(logic [31:0] src, logic [31:0] dst, logic vld);
        return vld && (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc=1, sticks at all-ones.
// Synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold once all-ones so the value never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core.
// Drives PC hold, IF2ID freeze/flush and the ID2EX bubble; sequences multi-cycle EX ops
// (MULT/DIV) and keeps saturating stall/flush performance counters.
// Build option FORWARDING_EN: when defined, the datapath forwards from EX/MEM and only a
// load in EX feeding the ID instruction stalls (1 cycle). When undefined, any pending write
// in EX or MEM to a source register stalls until the producer has left MEM.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_vld,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_wb_en,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mc_start,
    output logic              pc_freeze,
    output logic              if2id_freeze,
    output logic              if2id_flush,
    output logic              id2ex_bubble,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // The mc_start cycle is the first stall cycle, so MC_WAIT lasts MC_LAT-1 cycles and
    // the down-counter starts at MC_LAT-2.
    localparam int unsigned MC_CW   = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam int unsigned MC_INIT = (MC_LAT >= 2) ? (MC_LAT - 2) : 0;

    if (MC_LAT < 2) begin : g_bad_mc_lat
        $error("hazard_stall_ctrl: MC_LAT must be at least 2");
    end

    state_e           state_q, state_d;
    logic [MC_CW-1:0] mc_cnt_q, mc_cnt_d;

    logic pc_freeze_c;
    logic if2id_freeze_c;
    logic if2id_flush_c;
    logic id2ex_bubble_c;

    logic [CNT_W-1:0] stall_cnt_raw;
    logic [CNT_W-1:0] flush_cnt_raw;

    logic ex_match;
    logic mem_match;
    logic data_haz;

    // Source/destination compares against the producers in EX and MEM.
    always_comb begin
        ex_match  = src_match(32'(id_src1), 32'(ex_dst), 1'b1) ||
                    src_match(32'(id_src2), 32'(ex_dst), id_src2_vld);
        mem_match = src_match(32'(id_src1), 32'(mem_dst), 1'b1) ||
                    src_match(32'(id_src2), 32'(mem_dst), id_src2_vld);
    end

`ifdef FORWARDING_EN
    // Forwarding covers ALU results; only a load result is not ready in time.
    assign data_haz = ex_mem_read && ex_wb_en && ex_match;

    // MEM-stage producers are always forwarded, so they never stall.
    logic unused_mem;
    assign unused_mem = ^{mem_match, mem_wb_en};
`else
    // No forwarding: wait until the producer has left MEM.
    assign data_haz = (ex_wb_en && ex_match) || (mem_wb_en && mem_match);

    // Load vs ALU makes no difference without forwarding.
    logic unused_ex_mem_read;
    assign unused_ex_mem_read = ex_mem_read;
`endif

    // Next state and hazard outputs; everything is forced low while rst is held.
    always_comb begin
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        pc_freeze_c    = 1'b0;
        if2id_freeze_c = 1'b0;
        if2id_flush_c  = 1'b0;
        id2ex_bubble_c = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        // Squash the wrong-path fetches; a coincident mc_start is dropped.
                        if2id_flush_c  = 1'b1;
                        id2ex_bubble_c = 1'b1;
                    end else if (mc_start) begin
                        state_d        = MC_WAIT;
                        mc_cnt_d       = MC_CW'(MC_INIT);
                        pc_freeze_c    = 1'b1;
                        if2id_freeze_c = 1'b1;
                        id2ex_bubble_c = 1'b1;
                    end else if (data_haz) begin
                        pc_freeze_c    = 1'b1;
                        if2id_freeze_c = 1'b1;
                        id2ex_bubble_c = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // branch_taken and mc_start cannot legally occur while EX is busy.
                    pc_freeze_c    = 1'b1;
                    if2id_freeze_c = 1'b1;
                    id2ex_bubble_c = 1'b1;
                    if (mc_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - MC_CW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State and multi-cycle counter registers; reset aborts any MC sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_freeze_c),
        .cnt (stall_cnt_raw)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if2id_flush_c),
        .cnt (flush_cnt_raw)
    );

    assign pc_freeze    = pc_freeze_c;
    assign if2id_freeze = if2id_freeze_c;
    assign if2id_flush  = if2id_flush_c;
    assign id2ex_bubble = id2ex_bubble_c;
    assign mc_busy      = !rst && (state_q == MC_WAIT);
    assign stall_cnt    = rst ? '0 : stall_cnt_raw;
    assign flush_cnt    = rst ? '0 : flush_cnt_raw;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Counters are built 4 bits wide so that
// saturation can be reached in a short run.
module tb_hazard_stall_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned MC_LAT = 4;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_src2_vld;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_wb_en;
    logic              branch_taken;
    logic              mc_start;
    logic              pc_freeze;
    logic              if2id_freeze;
    logic              if2id_flush;
    logic              id2ex_bubble;
    logic              mc_busy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src2_vld  (id_src2_vld),
        .ex_dst       (ex_dst),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dst      (mem_dst),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mc_start     (mc_start),
        .pc_freeze    (pc_freeze),
        .if2id_freeze (if2id_freeze),
        .if2id_flush  (if2id_flush),
        .id2ex_bubble (id2ex_bubble),
        .mc_busy      (mc_busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs settle mid-cycle; checks run on the falling edge.
    task automatic sample();
        @(negedge clk);
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1      = '0;
        id_src2      = '0;
        id_src2_vld  = 1'b0;
        ex_dst       = '0;
        ex_wb_en     = 1'b0;
        ex_mem_read  = 1'b0;
        mem_dst      = '0;
        mem_wb_en    = 1'b0;
        branch_taken = 1'b0;
        mc_start     = 1'b0;
    endtask

    // Stall-side outputs in one call: {pc_freeze, if2id_freeze, id2ex_bubble, if2id_flush}.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, 32'({pc_freeze, if2id_freeze, id2ex_bubble, if2id_flush}), 32'(exp));
    endtask

    // Branch or new MC op while EX is busy is a pipeline protocol error.
    always @(negedge clk) begin
        if (!rst && mc_busy && (branch_taken || mc_start)) begin
            check("mc_wait_protocol", 32'(1), 32'(0));
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        // Outputs must be quiet in reset even with a branch request pending.
        branch_taken = 1'b1;
        sample();
        check_ctl("reset_ctl", 4'b0000);
        check("reset_busy", 32'(mc_busy), 32'(0));
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        sample();
        check("reset_stall_cnt", 32'(stall_cnt), 32'(0));
        check("reset_flush_cnt", 32'(flush_cnt), 32'(0));
        check_ctl("idle_ctl", 4'b0000);

        // r0 destination never stalls.
        next_cycle();
        ex_dst = '0; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        mem_dst = '0; mem_wb_en = 1'b1;
        id_src1 = '0; id_src2 = '0; id_src2_vld = 1'b1;
        sample();
        check_ctl("r0_no_stall", 4'b0000);

        // Immediate src2 is not compared.
        next_cycle();
        clear_inputs();
        id_src1 = 5'd1; id_src2 = 5'd5; id_src2_vld = 1'b0;
        ex_dst = 5'd5; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        mem_dst = 5'd5; mem_wb_en = 1'b1;
        sample();
        check_ctl("imm_src2_no_stall", 4'b0000);

`ifdef FORWARDING_EN
        // Load r3 in EX feeding ID: one stall cycle.
        next_cycle();
        clear_inputs();
        id_src1 = 5'd3; ex_dst = 5'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        sample();
        check_ctl("load_use_stall", 4'b1110);
        // Load moves to MEM, bubble in EX: forwarded, no stall.
        next_cycle();
        ex_wb_en = 1'b0; ex_mem_read = 1'b0; mem_dst = 5'd3; mem_wb_en = 1'b1;
        sample();
        check_ctl("load_use_release", 4'b0000);
        check("load_use_stall_cnt", 32'(stall_cnt), 32'(1));
        // Load-use through src2.
        next_cycle();
        clear_inputs();
        id_src2 = 5'd9; id_src2_vld = 1'b1; ex_dst = 5'd9; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        sample();
        check_ctl("load_use_src2", 4'b1110);
        // ALU producer in EX is forwarded.
        next_cycle();
        ex_mem_read = 1'b0;
        sample();
        check_ctl("alu_fwd_no_stall", 4'b0000);
        check("fwd_stall_cnt", 32'(stall_cnt), 32'(2));
`else
        // ALU writes r3, ID reads r3: stall while producer sits in EX then MEM.
        next_cycle();
        clear_inputs();
        id_src1 = 5'd3; ex_dst = 5'd3; ex_wb_en = 1'b1;
        sample();
        check_ctl("raw_ex_stall", 4'b1110);
        next_cycle();
        ex_wb_en = 1'b0; mem_dst = 5'd3; mem_wb_en = 1'b1;
        sample();
        check_ctl("raw_mem_stall", 4'b1110);
        next_cycle();
        mem_wb_en = 1'b0;
        sample();
        check_ctl("raw_release", 4'b0000);
        check("raw_stall_cnt", 32'(stall_cnt), 32'(2));
        // MEM producer hit through src2.
        next_cycle();
        clear_inputs();
        id_src2 = 5'd7; id_src2_vld = 1'b1; mem_dst = 5'd7; mem_wb_en = 1'b1;
        sample();
        check_ctl("raw_mem_src2", 4'b1110);
        next_cycle();
        clear_inputs();
        sample();
        check("nofwd_stall_cnt", 32'(stall_cnt), 32'(3));
`endif

        // Branch with coincident load-use hazard and mc_start: flush wins, no MC start.
        next_cycle();
        clear_inputs();
        id_src1 = 5'd3; ex_dst = 5'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        branch_taken = 1'b1; mc_start = 1'b1;
        sample();
        check_ctl("branch_over_haz", 4'b0011);
        next_cycle();
        clear_inputs();
        sample();
        check("branch_flush_cnt", 32'(flush_cnt), 32'(1));
        check("branch_no_mc", 32'(mc_busy), 32'(0));

        // Multi-cycle op: 4 freeze cycles, busy in the last 3.
        next_cycle();
        mc_start = 1'b1;
        sample();
        check_ctl("mc_start_ctl", 4'b1110);
        check("mc_start_busy", 32'(mc_busy), 32'(0));
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mc_start = 1'b0;
            sample();
            check_ctl($sformatf("mc_wait_ctl%0d", i), 4'b1110);
            check($sformatf("mc_wait_busy%0d", i), 32'(mc_busy), 32'(1));
        end
        next_cycle();
        sample();
        check_ctl("mc_done_ctl", 4'b0000);
        check("mc_done_busy", 32'(mc_busy), 32'(0));
`ifdef FORWARDING_EN
        check("mc_stall_cnt", 32'(stall_cnt), 32'(6));
`else
        check("mc_stall_cnt", 32'(stall_cnt), 32'(7));
`endif

        // Reset in the 2nd MC_WAIT cycle aborts to RUN.
        next_cycle();
        mc_start = 1'b1;
        next_cycle();
        mc_start = 1'b0;
        next_cycle();
        rst = 1'b1;
        sample();
        check_ctl("mc_rst_ctl", 4'b0000);
        check("mc_rst_busy", 32'(mc_busy), 32'(0));
        next_cycle();
        rst = 1'b0;
        sample();
        check_ctl("mc_abort_ctl", 4'b0000);
        check("mc_abort_busy", 32'(mc_busy), 32'(0));
        check("mc_abort_stall_cnt", 32'(stall_cnt), 32'(0));
        check("mc_abort_flush_cnt", 32'(flush_cnt), 32'(0));

        // Hold a hazard long enough to saturate the stall counter.
        next_cycle();
        id_src1 = 5'd4; ex_dst = 5'd4; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        for (int i = 0; i < 14; i++) next_cycle();
        sample();
        check("stall_cnt_14", 32'(stall_cnt), 32'(14));
        for (int i = 0; i < 6; i++) next_cycle();
        sample();
        check("stall_cnt_sat", 32'(stall_cnt), 32'(15));

        // Same for the flush counter; branches do not stall.
        next_cycle();
        branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) next_cycle();
        sample();
        check("flush_cnt_sat", 32'(flush_cnt), 32'(15));
        check("stall_cnt_hold", 32'(stall_cnt), 32'(15));
        check_ctl("branch_hold_ctl", 4'b0011);

        next_cycle();
        clear_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
